hyper_rx_burst_sched: RTL and testbench

Sequencer in front of the HyperBus/PSRAM RX datapath. It round-robin arbitrates RX transfer requests from NB_CH uDMA channels. Each granted transfer is split into PHY bursts that never cross a MAX_BURST_BYTES-aligned boundary. For every burst it drives the per-burst configuration the RX width-conversion buffer consumes: byte size, odd start address flag, memory select and the remaining 16-bit word count.

---
 rtl/hyper_rx_burst_sched.sv | 160 ++++++++++++++++
 tb/tb_hyper_rx_burst_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_rx_burst_sched.sv
// Round-robin RX transfer sequencer: splits each granted uDMA transfer into PHY bursts
// that never cross a MAX_BURST_BYTES boundary and tracks the words left in each burst.
module hyper_rx_burst_sched #(
    parameter int NB_CH           = 2,
    parameter int TRANS_SIZE      = 16,
    parameter int MAX_BURST_BYTES = 256
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NB_CH-1:0]            ch_req_i,
    input  logic [NB_CH*32-1:0]         ch_addr_i,
    input  logic [NB_CH*TRANS_SIZE-1:0] ch_size_i,
    input  logic [NB_CH*2-1:0]          ch_mem_sel_i,
    output logic [NB_CH-1:0]            ch_gnt_o,
    output logic [NB_CH-1:0]            ch_done_o,
    output logic                        phy_trans_valid_o,
    input  logic                        phy_trans_ready_i,
    output logic [31:0]                 phy_addr_o,
    output logic [TRANS_SIZE-1:0]       phy_words_o,
    output logic [TRANS_SIZE-1:0]       cfg_rx_size_o,
    output logic                        hyper_odd_saaddr_o,
    output logic [1:0]                  mem_sel_o,
    output logic [TRANS_SIZE-1:0]       remained_data_o,
    input  logic                        phy_rx_valid_i,
    output logic                        busy_o,
    output logic [2:0]                  active_ch_o
);

    // state | meaning
    // IDLE  | waiting for a request; also holds while a zero-size done is pending
    // ISSUE | burst command valid, waiting for PHY ready
    // DATA  | counting received 16-bit words of the current burst
    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

    localparam logic [31:0] BURST_MASK = 32'(MAX_BURST_BYTES - 1);

    state_t                state;
    logic [2:0]            rr_ptr;
    logic [31:0]           cur_addr;
    logic [TRANS_SIZE-1:0] cur_rem;
    logic                  zero_done;

    logic [31:0]           off;
    logic [31:0]           room;
    logic [31:0]           rem_ext;
    logic [TRANS_SIZE-1:0] bytes;
    logic [TRANS_SIZE-1:0] words;

    always_comb begin
        off     = cur_addr & BURST_MASK;
        room    = 32'(MAX_BURST_BYTES) - off;
        rem_ext = 32'(cur_rem);
        bytes   = (rem_ext < room) ? cur_rem : room[TRANS_SIZE-1:0];
        words   = (TRANS_SIZE'(cur_addr[0]) + bytes + TRANS_SIZE'(1)) >> 1;
    end

    logic                  found;
    logic [2:0]            win;
    logic [31:0]           win_addr;
    logic [TRANS_SIZE-1:0] win_size;
    logic [1:0]            win_mem;

    // Two passes give "first requester after the pointer, wrapping".
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_addr = '0;
        win_size = '0;
        win_mem  = '0;
        for (int k = 0; k < NB_CH; k++) begin
            if (!found && ch_req_i[k] && (3'(k) > rr_ptr)) begin
                found    = 1'b1;
                win      = 3'(k);
                win_addr = ch_addr_i[32*k +: 32];
                win_size = ch_size_i[TRANS_SIZE*k +: TRANS_SIZE];
                win_mem  = ch_mem_sel_i[2*k +: 2];
            end
        end
        for (int k = 0; k < NB_CH; k++) begin
            if (!found && ch_req_i[k] && (3'(k) <= rr_ptr)) begin
                found    = 1'b1;
                win      = 3'(k);
                win_addr = ch_addr_i[32*k +: 32];
                win_size = ch_size_i[TRANS_SIZE*k +: TRANS_SIZE];
                win_mem  = ch_mem_sel_i[2*k +: 2];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= IDLE;
            rr_ptr            <= 3'(NB_CH - 1);
            cur_addr          <= '0;
            cur_rem           <= '0;
            zero_done         <= 1'b0;
            ch_gnt_o          <= '0;
            ch_done_o         <= '0;
            phy_trans_valid_o <= 1'b0;
            mem_sel_o         <= '0;
            remained_data_o   <= '0;
            active_ch_o       <= '0;
        end else begin
            ch_gnt_o  <= '0;
            ch_done_o <= '0;
            zero_done <= 1'b0;
            if (zero_done) ch_done_o <= NB_CH'(1) << active_ch_o;
            case (state)
                IDLE: begin
                    // No new arbitration until the previous grant/done pulses have cleared.
                    if (found && !zero_done && ch_gnt_o == '0 && ch_done_o == '0) begin
                        ch_gnt_o    <= NB_CH'(1) << win;
                        cur_addr    <= win_addr;
                        cur_rem     <= win_size;
                        mem_sel_o   <= win_mem;
                        active_ch_o <= win;
                        rr_ptr      <= win;
                        if (win_size == '0) begin
                            zero_done <= 1'b1;
                        end else begin
                            state             <= ISSUE;
                            phy_trans_valid_o <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (phy_trans_ready_i) begin
                        phy_trans_valid_o <= 1'b0;
                        remained_data_o   <= words;
                        state             <= DATA;
                    end
                end
                DATA: begin
                    if (phy_rx_valid_i && remained_data_o != '0) begin
                        remained_data_o <= remained_data_o - TRANS_SIZE'(1);
                        if (remained_data_o == TRANS_SIZE'(1)) begin
                            cur_addr <= cur_addr + 32'(bytes);
                            cur_rem  <= cur_rem - bytes;
                            if (cur_rem == bytes) begin
                                state     <= IDLE;
                                ch_done_o <= NB_CH'(1) << active_ch_o;
                            end else begin
                                state             <= ISSUE;
                                phy_trans_valid_o <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o             = (state != IDLE);
    assign phy_addr_o         = busy_o ? cur_addr : '0;
    assign cfg_rx_size_o      = busy_o ? bytes : '0;
    assign phy_words_o        = busy_o ? words : '0;
    assign hyper_odd_saaddr_o = busy_o & cur_addr[0];

endmodule

// File: tb/tb_hyper_rx_burst_sched.sv
// Scoreboard bench for hyper_rx_burst_sched: random requests and PHY handshakes are checked
// against a transfer-level burst-split and round-robin model.
module tb_hyper_rx_burst_sched;
    localparam int NB_CH = 2;
    localparam int TS    = 16;
    localparam int MAXB  = 256;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b1;
    logic [NB_CH-1:0]     ch_req_i = '0;
    logic [NB_CH*32-1:0]  ch_addr_i = '0;
    logic [NB_CH*TS-1:0]  ch_size_i = '0;
    logic [NB_CH*2-1:0]   ch_mem_sel_i = '0;
    logic [NB_CH-1:0]     ch_gnt_o;
    logic [NB_CH-1:0]     ch_done_o;
    logic                 phy_trans_valid_o;
    logic                 phy_trans_ready_i = 1'b0;
    logic [31:0]          phy_addr_o;
    logic [TS-1:0]        phy_words_o;
    logic [TS-1:0]        cfg_rx_size_o;
    logic                 hyper_odd_saaddr_o;
    logic [1:0]           mem_sel_o;
    logic [TS-1:0]        remained_data_o;
    logic                 phy_rx_valid_i = 1'b0;
    logic                 busy_o;
    logic [2:0]           active_ch_o;

    hyper_rx_burst_sched #(.NB_CH(NB_CH), .TRANS_SIZE(TS), .MAX_BURST_BYTES(MAXB)) dut (
        .clk_i(clk), .rst_i(rst_i), .ch_req_i(ch_req_i), .ch_addr_i(ch_addr_i),
        .ch_size_i(ch_size_i), .ch_mem_sel_i(ch_mem_sel_i), .ch_gnt_o(ch_gnt_o),
        .ch_done_o(ch_done_o), .phy_trans_valid_o(phy_trans_valid_o),
        .phy_trans_ready_i(phy_trans_ready_i), .phy_addr_o(phy_addr_o),
        .phy_words_o(phy_words_o), .cfg_rx_size_o(cfg_rx_size_o),
        .hyper_odd_saaddr_o(hyper_odd_saaddr_o), .mem_sel_o(mem_sel_o),
        .remained_data_o(remained_data_o), .phy_rx_valid_i(phy_rx_valid_i),
        .busy_o(busy_o), .active_ch_o(active_ch_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [31:0] addr;
        int          bytes;
        int          words;
        int          odd;
        logic [1:0]  mem;
        bit          last;
    } burst_t;

    burst_t bq[$];
    int checks = 0;
    int errors = 0;
    int hold_cnt = 0;

    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Transfer-level model: chop [addr, addr+size) at every MAXB-aligned boundary.
    function automatic void push_xfer(int ch, logic [31:0] addr, int size, logic [1:0] mem);
        int rem = size;
        logic [31:0] a = addr;
        int room;
        burst_t b;
        while (rem > 0) begin
            room    = MAXB - int'(a % MAXB);
            b.ch    = ch;
            b.addr  = a;
            b.bytes = (rem < room) ? rem : room;
            b.odd   = int'(a[0]);
            b.words = (b.odd + b.bytes + 1) / 2;
            b.mem   = mem;
            rem     = rem - b.bytes;
            b.last  = (rem == 0);
            bq.push_back(b);
            a = a + 32'(b.bytes);
        end
    endfunction

    function automatic int rr_pick(logic [NB_CH-1:0] req, int last);
        for (int i = 1; i <= NB_CH; i++)
            if (req[(last + i) % NB_CH]) return (last + i) % NB_CH;
        return -1;
    endfunction

    function automatic void cmp_cmd(burst_t b);
        chk("phy_addr", phy_addr_o, b.addr);
        chk("cfg_rx_size", cfg_rx_size_o, b.bytes);
        chk("phy_words", phy_words_o, b.words);
        chk("odd_saaddr", hyper_odd_saaddr_o, b.odd);
        chk("mem_sel", mem_sel_o, b.mem);
        chk("active_ch", active_ch_o, b.ch);
    endfunction

    // Monitor / scoreboard
    initial begin
        bit in_data, start_data, done_next;
        int done_ch, left, rr_last, w;
        burst_t cur;
        logic [NB_CH-1:0]    p_req;
        logic [NB_CH*32-1:0] p_addr;
        logic [NB_CH*TS-1:0] p_size;
        logic [NB_CH*2-1:0]  p_mem;
        in_data = 0; done_next = 0; done_ch = 0; left = 0; rr_last = NB_CH - 1;
        p_req = '0; p_addr = '0; p_size = '0; p_mem = '0;
        forever begin
            @(negedge clk);
            start_data = 0;
            if (rst_i) begin
                bq.delete();
                in_data = 0; done_next = 0; rr_last = NB_CH - 1;
            end else begin
                chk("done", ch_done_o, done_next ? (1 << done_ch) : 0);
                done_next = 0;
                if (ch_gnt_o != '0) begin
                    w = rr_pick(p_req, rr_last);
                    chk("grant", ch_gnt_o, (w < 0) ? 0 : (1 << w));
                    if (w >= 0) begin
                        rr_last = w;
                        chk("grant_active_ch", active_ch_o, w);
                        chk("grant_mem_sel", mem_sel_o, p_mem[2*w +: 2]);
                        push_xfer(w, p_addr[32*w +: 32], int'(p_size[TS*w +: TS]), p_mem[2*w +: 2]);
                        if (p_size[TS*w +: TS] == '0) begin
                            done_next = 1; done_ch = w;
                        end
                    end
                end
                if (in_data) begin
                    chk("busy_in_data", busy_o, 1);
                    chk("valid_in_data", phy_trans_valid_o, 0);
                    chk("remained", remained_data_o, left);
                    cmp_cmd(cur);
                    if (phy_rx_valid_i) begin
                        left--;
                        if (left == 0) begin
                            in_data = 0;
                            if (cur.last) begin done_next = 1; done_ch = cur.ch; end
                        end
                    end
                end else if (phy_trans_valid_o) begin
                    chk("remained_in_issue", remained_data_o, 0);
                    if (bq.size() == 0) begin
                        chk("unexpected_cmd", phy_trans_valid_o, 0);
                    end else begin
                        cmp_cmd(bq[0]);
                        if (phy_trans_ready_i) begin
                            cur = bq.pop_front();
                            left = cur.words;
                            start_data = 1;
                        end
                    end
                end
                if (start_data) in_data = 1;
            end
            p_req = ch_req_i; p_addr = ch_addr_i; p_size = ch_size_i; p_mem = ch_mem_sel_i;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ch_req_i = ch_req_i & ~ch_gnt_o;
        if (hold_cnt > 0) begin
            phy_trans_ready_i = 1'b0;
            phy_rx_valid_i    = 1'b1;
            hold_cnt--;
        end else begin
            phy_trans_ready_i = ($urandom_range(0, 3) != 0);
            phy_rx_valid_i    = ($urandom_range(0, 4) != 0);
        end
    endtask

    task automatic issue(int k, logic [31:0] a, int s, logic [1:0] m);
        ch_req_i[k]          = 1'b1;
        ch_addr_i[32*k +: 32] = a;
        ch_size_i[TS*k +: TS] = TS'(s);
        ch_mem_sel_i[2*k +: 2] = m;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < 5000) begin
            tick();
            n++;
            if (ch_req_i == '0 && !busy_o && bq.size() == 0) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) chk("idle_timeout", quiet, 4);
    endtask

    task automatic check_zero_outputs(string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_valid"}, phy_trans_valid_o, 0);
        chk({tag, "_gnt"}, ch_gnt_o, 0);
        chk({tag, "_done"}, ch_done_o, 0);
        chk({tag, "_remained"}, remained_data_o, 0);
        chk({tag, "_active"}, active_ch_o, 0);
        chk({tag, "_mem_sel"}, mem_sel_o, 0);
        chk({tag, "_addr"}, phy_addr_o, 0);
        chk({tag, "_words"}, phy_words_o, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return 32'($urandom);
            1: return (32'($urandom) & 32'hFFFF_FF00) | (32'hFF - 32'($urandom_range(0, 15)));
            2: return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: return 32'($urandom) & 32'hFFFF_FF00;
        endcase
    endfunction

    initial begin
        int found;
        rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        check_zero_outputs("reset");

        issue(0, 32'h0000_0100, 64, 2'b01);
        wait_idle();
        issue(0, 32'h0000_01F1, 40, 2'b11);
        wait_idle();

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int r = 0; r < 2; r++) begin
            issue(0, 32'h0000_2000 + 32'(r * 16), 20, 2'b10);
            issue(1, 32'h0000_3003, 30, 2'b01);
            wait_idle();
        end

        issue(1, 32'h0000_5555, 0, 2'b11);
        wait_idle();

        hold_cnt = 7;
        issue(0, 32'h0000_0A0F, 300, 2'b10);
        wait_idle();

        issue(0, 32'h0000_0400, 64, 2'b10);
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            tick();
            if (busy_o && !phy_trans_valid_o && remained_data_o == 7) found = 1;
        end
        chk("reached_rem7", found, 1);
        ch_req_i = '0;
        rst_i = 1'b1;
        tick();
        check_zero_outputs("midburst_reset");
        rst_i = 1'b0;
        repeat (3) tick();
        issue(1, 32'h0000_0FFE, 10, 2'b01);
        wait_idle();

        for (int it = 0; it < 60; it++) begin
            for (int k = 0; k < NB_CH; k++)
                if (!ch_req_i[k] && $urandom_range(0, 1) == 1)
                    issue(k, rand_addr(),
                          ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 300)),
                          2'($urandom_range(0, 3)));
            repeat ($urandom_range(1, 40)) tick();
        end
        wait_idle();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
